// File: rtl/param_pwm_compare.sv
// PWM generator driven by an upstream wrap counter; duty threshold is shadowed and
// committed only at period wrap. All outputs registered (1 cycle) except duty_ready.
module param_pwm_compare #(
  parameter int W   = 16,
  parameter int TOP = 39999
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         cnt_en,
  input  logic [W-1:0] cnt,
  input  logic         run,
  input  logic         pol,
  input  logic [W-1:0] duty_data,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm_out,
  output logic         period_pulse,
  output logic         cmp_pulse,
  output logic         upd_done
);

  localparam logic [W-1:0] TOP_V    = W'(TOP);
  localparam logic [W:0]   FULL_EXT = (W+1)'(TOP + 1);
  localparam logic [W-1:0] FULL_V   = W'(TOP + 1);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, STOPPING} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] duty_act_q, duty_act_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pending_q, pending_d;
  logic         pwm_q, pwm_d;
  logic         per_q, per_d;
  logic         cmp_q, cmp_d;
  logic         upd_q, upd_d;

  logic         wrap;
  logic         gen;
  logic         active;
  logic         load;
  logic [W-1:0] duty_clamp;

  assign wrap       = cnt_en && (cnt == TOP_V);
  assign gen        = (state_q == RUN) || (state_q == STOPPING);
  assign active     = gen && (cnt < duty_act_q);
  assign duty_ready = !pending_q;
  assign load       = duty_valid && !pending_q;
  // Anything above TOP+1 already means "always active"; saturate so the compare stays meaningful.
  assign duty_clamp = ({1'b0, duty_data} > FULL_EXT) ? FULL_V : duty_data;

  always_comb begin
    state_d    = state_q;
    duty_act_d = duty_act_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    upd_d      = 1'b0;

    case (state_q)
      IDLE:     if (run) state_d = ARMED;
      ARMED: begin
        if (!run)      state_d = IDLE;
        else if (wrap) state_d = RUN;
      end
      RUN:      if (!run) state_d = STOPPING;
      STOPPING: begin
        if (run)       state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase

    // Load needs pending low and commit needs it high, so the two never collide.
    if (load) begin
      shadow_d  = duty_clamp;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      duty_act_d = shadow_q;
      pending_d  = 1'b0;
      upd_d      = 1'b1;
    end

    pwm_d = active ^ pol;
    per_d = (wrap && gen) || ((state_q == ARMED) && run && wrap);
    cmp_d = gen && cnt_en && (cnt == duty_act_q) && (duty_act_q != '0) && (duty_act_q <= TOP_V);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      duty_act_q <= '0;
      shadow_q   <= '0;
      pending_q  <= 1'b0;
      pwm_q      <= 1'b0;
      per_q      <= 1'b0;
      cmp_q      <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_act_q <= duty_act_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      pwm_q      <= pwm_d;
      per_q      <= per_d;
      cmp_q      <= cmp_d;
      upd_q      <= upd_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_pulse = per_q;
  assign cmp_pulse    = cmp_q;
  assign upd_done     = upd_q;

endmodule
